// File: rtl/caliptra_fpga_apb_initiator_pkg.sv
// rtl/caliptra_fpga_apb_initiator_pkg.sv - shared types for the FPGA APB initiator
//
// Purpose: FSM state enum plus the packed command and response records used by
// caliptra_fpga_apb_initiator. The struct field widths follow the localparams
// below, which match the top-level parameter defaults.
// Ports: none (package).
package caliptra_fpga_apb_initiator_pkg;

  localparam int unsigned APB_ADDR_W   = 32;
  localparam int unsigned APB_DATA_W   = 32;
  localparam int unsigned APB_PAUSER_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic                    write;
    logic [APB_ADDR_W-1:0]   addr;
    logic [APB_DATA_W-1:0]   wdata;
    logic [APB_PAUSER_W-1:0] pauser;
    logic [2:0]              pprot;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/caliptra_fpga_apb_timeout_ctr.sv
// rtl/caliptra_fpga_apb_timeout_ctr.sv - ACCESS-phase wait-state counter
//
// Purpose: counts qualified wait cycles of one APB ACCESS phase and flags the
// increment that brings the count to LIMIT.
// Ports:
//   aclk, rstn  clock, asynchronous active-low reset
//   clear       restart the count (ACCESS entry)
//   inc         one qualified cycle without pready
//   expired     this cycle's increment reaches LIMIT
module caliptra_fpga_apb_timeout_ctr #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic aclk,
  input  logic rstn,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Fire on the increment itself so the FSM leaves ACCESS on the LIMIT-th
  // qualified wait cycle rather than one cycle later.
  assign expired = inc && (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/caliptra_fpga_apb_initiator.sv
// rtl/caliptra_fpga_apb_initiator.sv - hardware APB initiator for the FPGA sync wrapper
//
// Purpose: accepts one command at a time, runs an APB SETUP/ACCESS sequence
// whose phases advance only on pclk_en cycles, and returns one held response.
// Optional feature: define CALIPTRA_FPGA_APB_TIMEOUT_EN to abort ACCESS after
// TIMEOUT_CYCLES qualified wait cycles; otherwise ACCESS waits indefinitely.
// Ports:
//   aclk, rstn                         clock, asynchronous active-low reset
//   pclk_en                            target gated-clock tick this cycle
//   cmd_valid/cmd_ready + cmd_*        command handshake and fields
//   rsp_valid/rsp_ready + rsp_*        response handshake and fields
//   busy                               not idle
//   psel, penable, pwrite, paddr,
//   pwdata, pprot, pauser              APB request
//   prdata, pready, pslverr            APB responder returns
module caliptra_fpga_apb_initiator
  import caliptra_fpga_apb_initiator_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W,
  parameter int unsigned DATA_W         = APB_DATA_W,
  parameter int unsigned PAUSER_W       = APB_PAUSER_W,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                aclk,
  input  logic                rstn,
  input  logic                pclk_en,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [PAUSER_W-1:0] cmd_pauser,
  input  logic [2:0]          cmd_pprot,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                busy,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [2:0]          pprot,
  output logic [PAUSER_W-1:0] pauser,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  apb_state_e state_q, state_d;
  apb_cmd_t   cmd_q;
  apb_rsp_t   rsp_q;
  logic       xfer_done;
  logic       timeout_hit;

  // Only a pready on a gated-clock tick counts; other pready cycles are ignored.
  assign xfer_done = (state_q == ST_ACCESS) && pclk_en && pready;

`ifdef CALIPTRA_FPGA_APB_TIMEOUT_EN
  logic access_entry;
  logic wait_tick;

  assign access_entry = (state_q == ST_SETUP) && pclk_en;
  assign wait_tick    = (state_q == ST_ACCESS) && pclk_en && !pready;

  caliptra_fpga_apb_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .aclk    (aclk),
    .rstn    (rstn),
    .clear   (access_entry),
    .inc     (wait_tick),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
  // TIMEOUT_CYCLES has no effect in this build.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cmd_valid) state_d = ST_SETUP;
      ST_SETUP:  if (pclk_en) state_d = ST_ACCESS;
      // pready wins over a limit reached on the same cycle: timeout_hit
      // can only be raised when pready is low.
      ST_ACCESS: if (xfer_done || timeout_hit) state_d = ST_RESP;
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // cmd_ready is gated with rstn so it stays low for the whole reset.
  always_comb begin
    cmd_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = rstn;
        busy      = 1'b0;
      end
      ST_SETUP:  psel = 1'b1;
      ST_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
      end
      ST_RESP:   rsp_valid = 1'b1;
      default:   busy = 1'b1;
    endcase
  end

  // Payload is only loaded on a handshake, so it is stable through SETUP and
  // ACCESS and keeps its last value afterwards.
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      cmd_q <= '0;
      rsp_q <= '0;
    end else begin
      if ((state_q == ST_IDLE) && cmd_valid) begin
        cmd_q <= '{write:  cmd_write,
                   addr:   cmd_addr,
                   wdata:  cmd_wdata,
                   pauser: cmd_pauser,
                   pprot:  cmd_pprot};
      end
      if (xfer_done) begin
        rsp_q <= '{rdata:   cmd_q.write ? '0 : prdata,
                   err:     pslverr,
                   timeout: 1'b0};
      end else if (timeout_hit) begin
        rsp_q <= '{rdata: '0, err: 1'b1, timeout: 1'b1};
      end
    end
  end

  assign pwrite      = cmd_q.write;
  assign paddr       = cmd_q.addr;
  assign pwdata      = cmd_q.wdata;
  assign pprot       = cmd_q.pprot;
  assign pauser      = cmd_q.pauser;
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_caliptra_fpga_apb_initiator.sv
// tb/tb_caliptra_fpga_apb_initiator.sv - self-checking bench for caliptra_fpga_apb_initiator
module tb_caliptra_fpga_apb_initiator;

  localparam int TMO = 8;
`ifdef CALIPTRA_FPGA_APB_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        rstn = 1'b0;
  logic        pclk_en = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [31:0] cmd_pauser = '0;
  logic [2:0]  cmd_pprot = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, pauser;
  logic [2:0]  pprot;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  caliptra_fpga_apb_initiator #(
    .ADDR_W(32), .DATA_W(32), .PAUSER_W(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .aclk(aclk), .rstn(rstn), .pclk_en(pclk_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_pauser(cmd_pauser),
    .cmd_pprot(cmd_pprot), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .busy(busy), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pprot(pprot), .pauser(pauser),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 aclk = ~aclk;

  int gcyc = 0;
  always @(posedge aclk) gcyc <= gcyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pauser;
    logic [2:0]  pprot;
    int          nwait;     // qualified wait cycles before the responder says pready
    logic [31:0] prdata;
    bit          slverr;
    int          period;    // pclk_en high one cycle in every `period`
    bit          force_rdy; // pready held high for the whole ACCESS phase
    logic [31:0] exp_rdata;
    bit          exp_err;
    bit          exp_tmo;
    int          exp_qual;  // qualified ACCESS cycles until RESP
  } vec_t;

  function automatic vec_t mk(bit w, logic [31:0] a, logic [31:0] d, logic [31:0] u,
                              logic [2:0] p, int nw, logic [31:0] rd, bit se, int per,
                              bit fr, logic [31:0] er, bit ee, bit et, int eq);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = d; v.pauser = u; v.pprot = p;
    v.nwait = nw; v.prdata = rd; v.slverr = se; v.period = per; v.force_rdy = fr;
    v.exp_rdata = er; v.exp_err = ee; v.exp_tmo = et; v.exp_qual = eq;
    return v;
  endfunction

  // Reference: a transfer either completes on the (nwait+1)-th qualified ACCESS
  // cycle, or, with the timeout built in, aborts on the TMO-th one.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (TMO_ON && v.nwait >= TMO) begin
      r.exp_rdata = '0; r.exp_err = 1'b1; r.exp_tmo = 1'b1; r.exp_qual = TMO;
    end else begin
      r.exp_rdata = v.write ? 32'h0 : v.prdata;
      r.exp_err = v.slverr; r.exp_tmo = 1'b0; r.exp_qual = v.nwait + 1;
    end
    return r;
  endfunction

  task automatic pulse_reset();
    rstn = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; pready = 1'b0;
    @(posedge aclk); #1;
    rstn = 1'b1;
  endtask

  task automatic do_xfer(input vec_t v, input string tag);
    int  lat, setup_qual, acc_qual, acc_done, hold;
    bit  payload_ok, seen_rsp, held_ok;
    logic [31:0] r_rdata;
    logic r_err, r_tmo;
    cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
    cmd_pauser = v.pauser; cmd_pprot = v.pprot; cmd_valid = 1'b1;
    rsp_ready = 1'b0; pready = 1'b0;
    pclk_en = (gcyc % v.period) == 0;
    check({tag, ".cmd_ready"}, cmd_ready, 1);
    @(posedge aclk); #1;
    // Scramble the command inputs so only the captured copy can drive APB.
    cmd_valid = 1'b0; cmd_write = $urandom_range(0, 1); cmd_addr = $urandom;
    cmd_wdata = $urandom; cmd_pauser = $urandom; cmd_pprot = 3'($urandom);
    lat = 1; setup_qual = 0; acc_qual = 0; acc_done = 0;
    payload_ok = 1'b1; seen_rsp = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (rsp_valid) begin
        seen_rsp = 1'b1;
        break;
      end
      if (psel && ({pwrite, paddr, pwdata, pauser, pprot} !==
                   {v.write, v.addr, v.wdata, v.pauser, v.pprot}))
        payload_ok = 1'b0;
      pclk_en = (gcyc % v.period) == 0;
      if (psel && penable) begin
        pready = (acc_qual == v.nwait) || v.force_rdy ||
                 (!pclk_en && ($urandom_range(0, 1) == 1));
        prdata  = (pready && pclk_en) ? v.prdata : $urandom;
        pslverr = (pready && pclk_en) ? v.slverr : 1'($urandom_range(0, 1));
        if (pclk_en) acc_qual++;
        if (pclk_en && pready) acc_done++;
      end else begin
        pready = 1'($urandom_range(0, 1)); prdata = $urandom; pslverr = 1'b0;
        if (psel && pclk_en) setup_qual++;
      end
      @(posedge aclk); #1;
      lat++;
    end
    pready = 1'b0;
    check({tag, ".rsp_valid_seen"}, seen_rsp, 1);
    if (!seen_rsp) begin
      pulse_reset();
      return;
    end
    check({tag, ".payload_stable"}, payload_ok, 1);
    check({tag, ".setup_qual"}, setup_qual, 1);
    check({tag, ".access_qual"}, acc_qual, v.exp_qual);
    check({tag, ".access_done"}, acc_done, v.exp_tmo ? 0 : 1);
    if (v.period == 1) check({tag, ".latency"}, lat, v.exp_qual + 2);
    check({tag, ".apb_idle_in_resp"}, {psel, penable, busy}, 3'b001);
    check({tag, ".rsp_rdata"}, rsp_rdata, v.exp_rdata);
    check({tag, ".rsp_err"}, rsp_err, v.exp_err);
    check({tag, ".rsp_timeout"}, rsp_timeout, v.exp_tmo);
    // Hold the response while a new command is offered; it must not be taken.
    r_rdata = rsp_rdata; r_err = rsp_err; r_tmo = rsp_timeout;
    held_ok = 1'b1;
    cmd_valid = 1'b1;
    hold = $urandom_range(0, 3);
    for (int i = 0; i < hold; i++) begin
      pclk_en = 1'($urandom_range(0, 1));
      @(posedge aclk); #1;
      if (!rsp_valid || cmd_ready || psel ||
          {rsp_rdata, rsp_err, rsp_timeout} !== {r_rdata, r_err, r_tmo})
        held_ok = 1'b0;
    end
    check({tag, ".rsp_held"}, held_ok, 1);
    rsp_ready = 1'b1;
    @(posedge aclk); #1;
    rsp_ready = 1'b0;
    check({tag, ".back_to_idle"}, {rsp_valid, busy, psel, cmd_ready}, 4'b0001);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    vec_t v;

    tbl.push_back(mk(1, 32'h3003_0000, 32'hDEAD_BEEF, 32'h1, 3'd0, 0, 32'h0,         0, 1, 0, 32'h0,         0, 0, 1));
    tbl.push_back(mk(0, 32'h3003_0004, 32'h0,         32'h2, 3'd1, 3, 32'h1234_5678, 0, 1, 0, 32'h1234_5678, 0, 0, 4));
    tbl.push_back(mk(0, 32'h3003_0008, 32'h0,         32'h3, 3'd2, 0, 32'hCAFE_F00D, 0, 4, 1, 32'hCAFE_F00D, 0, 0, 1));
    tbl.push_back(mk(1, 32'h3003_000C, 32'h0BAD_F00D, 32'h4, 3'd3, 0, 32'h5555_AAAA, 1, 1, 0, 32'h0,         1, 0, 1));
    tbl.push_back(mk(0, 32'h3003_0010, 32'h0,         32'h5, 3'd7, 2, 32'h0000_ABCD, 1, 2, 0, 32'h0000_ABCD, 1, 0, 3));
    tbl.push_back(mk(1, 32'h3003_0014, 32'h1357_9BDF, 32'h6, 3'd4, 1, 32'h0,         0, 3, 0, 32'h0,         0, 0, 2));
`ifdef CALIPTRA_FPGA_APB_TIMEOUT_EN
    tbl.push_back(mk(0, 32'h3003_0018, 32'h0,         32'h7, 3'd5, 100, 32'hFFFF_FFFF, 0, 1, 0, 32'h0,       1, 1, 8));
    tbl.push_back(mk(0, 32'h3003_001C, 32'h0,         32'h8, 3'd6, 7,   32'h7777_0008, 0, 1, 0, 32'h7777_0008, 0, 0, 8));
    tbl.push_back(mk(1, 32'h3003_0020, 32'h2468_ACE0, 32'h9, 3'd1, 100, 32'h0,         1, 2, 0, 32'h0,       1, 1, 8));
`endif

    // Reset state
    #1;
    check("reset.cmd_ready", cmd_ready, 0);
    check("reset.outputs",
          {psel, penable, pwrite, busy, rsp_valid, rsp_err, rsp_timeout, rsp_rdata, paddr, pwdata, pprot},
          '0);
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    rstn = 1'b1;
    #1;
    check("reset_release.cmd_ready", cmd_ready, 1);
    check("reset_release.busy", busy, 0);

    foreach (tbl[i]) do_xfer(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      v = mk(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, 3'($urandom),
             $urandom_range(0, TMO_ON ? 10 : 5), $urandom, 1'($urandom_range(0, 1)),
             $urandom_range(1, 4), 0, 0, 0, 0, 0);
      do_xfer(model(v), $sformatf("rand%0d", i));
    end

    // Reset in the middle of ACCESS, with a command held on cmd_valid.
    cmd_write = 1'b0; cmd_addr = 32'h3003_0040; cmd_valid = 1'b1;
    pclk_en = 1'b1; pready = 1'b0;
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
    @(posedge aclk); #1;
    check("midrst.in_access", {psel, penable}, 2'b11);
    for (int i = 0; i < (TMO_ON ? 3 : 30); i++) begin
      @(posedge aclk); #1;
    end
    check("midrst.still_waiting", {psel, penable, rsp_valid}, 3'b110);
    rstn = 1'b0;
    cmd_addr = 32'hA5A5_0000; cmd_valid = 1'b1;
    #1;
    check("midrst.async_drop", {psel, penable, busy, rsp_valid, cmd_ready}, 5'b0);
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    check("midrst.held_in_reset", {psel, busy, rsp_valid, cmd_ready}, 4'b0);
    rstn = 1'b1;
    #1;
    check("midrst.ready_after", {cmd_ready, rsp_valid}, 2'b10);
    @(posedge aclk); #1;
    check("midrst.accept_after", {psel, penable, paddr}, {1'b1, 1'b0, 32'hA5A5_0000});
    cmd_valid = 1'b0;
    pulse_reset();
    #1;
    check("final.idle", {busy, psel, rsp_valid, cmd_ready}, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
